// File: rtl/exu_alu_swc.sv
// exu_alu_swc: sequenced integer execute unit. One ALU op per start pulse:
// reads rs1/rs2 (or takes imm) over the shared tristate regfile bus, computes,
// and writes rd back over the same bus.
//
// Ports:
//   hclk, hrstn             clock, async active-low reset
//   start, stall            op request (IDLE only), global freeze
//   op, imm_sel, imm        operation, operand-B select, sign-extended immediate
//   rs1, rs2, rd            register indices
//   reg_raddr_*/reg_ren_*   regfile read groups (tristate, driven in RD)
//   reg_rdata_*             regfile read data (valid in CAP)
//   reg_waddr/wen/wdata     regfile write group (tristate, driven in WB)
//   busy, done, illegal     status: not IDLE, completion pulse, rejected op pulse
//
// state | meaning
// IDLE  | waiting for start; latches the request
// RD    | drives regfile read addresses/enables
// CAP   | regfile data valid; captures operands A/B
// EXE   | computes result (iterative shifts stay here shamt+1 cycles)
// WB    | drives regfile write, pulses done
module exu_alu_swc #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int SHIFT_ITER = 0
) (
    input  logic            hclk,
    input  logic            hrstn,
    input  logic            start,
    input  logic            stall,
    input  logic [3:0]      op,
    input  logic            imm_sel,
    input  logic [XLEN-1:0] imm,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    inout  logic [AW-1:0]   reg_raddr_1,
    inout  logic [AW-1:0]   reg_raddr_2,
    inout  logic            reg_ren_1,
    inout  logic            reg_ren_2,
    input  logic [XLEN-1:0] reg_rdata_1,
    input  logic [XLEN-1:0] reg_rdata_2,
    inout  logic [AW-1:0]   reg_waddr,
    inout  logic            reg_wen,
    inout  logic [XLEN-1:0] reg_wdata,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_EXE, S_WB} state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic            imm_sel_q, imm_sel_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            illegal_q, illegal_d;

    logic            op_ok;
    logic            op_is_shift;
    logic            iter_shift;
    logic [XLEN-1:0] b_in;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] step_res;

    // SUB has no immediate form, so it is rejected along with unused opcodes.
    assign op_ok       = (op <= 4'd9) && !((op == 4'd1) && imm_sel);
    assign op_is_shift = (op_q == 4'd2) || (op_q == 4'd6) || (op_q == 4'd7);
    assign iter_shift  = (SHIFT_ITER != 0) && op_is_shift;
    assign b_in        = imm_sel_q ? imm_q : reg_rdata_2;
    assign shamt       = b_q[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (op_q)
            4'd0: alu_res = a_q + b_q;
            4'd1: alu_res = a_q - b_q;
            4'd2: alu_res = a_q << shamt;
            4'd3: alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            4'd4: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            4'd5: alu_res = a_q ^ b_q;
            4'd6: alu_res = a_q >> shamt;
            4'd7: alu_res = $signed(a_q) >>> shamt;
            4'd8: alu_res = a_q | b_q;
            4'd9: alu_res = a_q & b_q;
            default: alu_res = '0;
        endcase
    end

    // One-bit step of the iterative shifter; res_q holds the partial result.
    always_comb begin
        step_res = res_q;
        case (op_q)
            4'd2:    step_res = {res_q[XLEN-2:0], 1'b0};
            4'd6:    step_res = {1'b0, res_q[XLEN-1:1]};
            default: step_res = {res_q[XLEN-1], res_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        imm_sel_d = imm_sel_q;
        imm_d     = imm_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        if (stall) begin
            // A pending illegal pulse is held and shows once stall drops.
            illegal_d = illegal_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d      = op;
                        imm_sel_d = imm_sel;
                        imm_d     = imm;
                        rs1_d     = rs1;
                        rs2_d     = rs2;
                        rd_d      = rd;
                        if (op_ok) state_d = S_RD;
                        else       illegal_d = 1'b1;
                    end
                end
                S_RD: state_d = S_CAP;
                S_CAP: begin
                    a_d     = reg_rdata_1;
                    b_d     = b_in;
                    cnt_d   = b_in[SW-1:0];
                    res_d   = reg_rdata_1;
                    state_d = S_EXE;
                end
                S_EXE: begin
                    if (iter_shift) begin
                        if (cnt_q == '0) begin
                            state_d = S_WB;
                        end else begin
                            res_d = step_res;
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end else begin
                        res_d   = alu_res;
                        state_d = S_WB;
                    end
                end
                S_WB:    state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            imm_sel_q <= imm_sel_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Bus groups float unless their enable is active; stall cuts them at once.
    logic rd1_drv, rd2_drv, wb_drv;
    assign rd1_drv = (state_q == S_RD) && !stall;
    assign rd2_drv = rd1_drv && !imm_sel_q;
    // x0 writes are dropped by leaving the whole write group undriven.
    assign wb_drv  = (state_q == S_WB) && !stall && (rd_q != '0);

    assign reg_raddr_1 = rd1_drv ? rs1_q : {AW{1'bz}};
    assign reg_ren_1   = rd1_drv ? 1'b1  : 1'bz;
    assign reg_raddr_2 = rd2_drv ? rs2_q : {AW{1'bz}};
    assign reg_ren_2   = rd2_drv ? 1'b1  : 1'bz;
    assign reg_waddr   = wb_drv  ? rd_q  : {AW{1'bz}};
    assign reg_wen     = wb_drv  ? 1'b1  : 1'bz;
    assign reg_wdata   = wb_drv  ? res_q : {XLEN{1'bz}};

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_WB) && !stall;
    assign illegal = illegal_q && !stall;

endmodule

// File: doc/exu_alu_swc.md
Name: exu_alu_swc

Overview:
- Parametrised successor to the fixed 32-bit register-register execute unit.
- Runs one integer ALU op per start pulse: reads rs1 and rs2 (or takes an immediate), computes, writes rd.
- All regfile traffic goes over the shared tristate regfile bus.
- Sequencing is an internal FSM with a start/busy/done handshake, replacing the external cycle counter. Adds immediate mode, x0 write suppression, illegal-op flagging and an optional iterative shifter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- AW, 5, register address width.
- SHIFT_ITER, 0: 0 = single-cycle barrel shift; 1 = iterative shift, 1 bit per cycle.

Ports:
- hclk  input  1  clock.
- hrstn  input  1  reset.
- start  input  1  begin op; sampled only in IDLE.
- stall  input  1  global freeze.
- op  input  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10-15 illegal.
- imm_sel  input  1  1: operand B = imm.
- imm  input  XLEN  immediate, already sign-extended.
- rs1, rs2, rd  input  AW  register indices.
- reg_raddr_1, reg_raddr_2  inout  AW  regfile read addresses.
- reg_ren_1, reg_ren_2  inout  1  regfile read enables.
- reg_rdata_1, reg_rdata_2  input  XLEN  regfile read data.
- reg_waddr  inout  AW  regfile write address.
- reg_wen  inout  1  regfile write enable.
- reg_wdata  inout  XLEN  regfile write data.
- busy  output  1  FSM not IDLE.
- done  output  1  one-cycle completion pulse.
- illegal  output  1  one-cycle pulse: op rejected.

Interface decision: reset hrstn, asynchronous, active-low; clock hclk.

Behaviour:
- Reset (async, mid-op included):
  - FSM to IDLE; busy=0, done=0, illegal=0.
  - All internal registers cleared.
  - Every inout bus signal at Z.
  - No write issued.
- Bus drive:
  - Each inout group is driven only while its enable is asserted, otherwise Z.
  - Read group is driven in RD, write group in WB.
  - Any group's drive is gated off combinationally while stall=1.
- FSM states: IDLE, RD, CAP, EXE, WB.
  - IDLE, start=1, stall=0: latch op/imm_sel/imm/rs1/rs2/rd.
    - op illegal, or op==SUB with imm_sel=1: pulse illegal next cycle, stay IDLE, no bus activity.
    - Otherwise go to RD.
  - RD (1 cycle):
    - Drive reg_raddr_1=rs1, reg_ren_1=1.
    - Drive reg_raddr_2=rs2, reg_ren_2=1 only if imm_sel=0.
    - Go to CAP.
  - CAP (1 cycle):
    - Regfile data is valid this cycle.
    - At the closing edge, capture A=reg_rdata_1 and B=(imm_sel ? imm : reg_rdata_2).
    - Go to EXE.
  - EXE, non-shift op or SHIFT_ITER=0: compute result in 1 cycle, go to WB.
  - EXE, shift op with SHIFT_ITER=1:
    - Load count = B[log2(XLEN)-1:0].
    - Each cycle shift by 1 (SRA replicates the MSB) and decrement count.
    - Go to WB when count==0; count 0 on entry takes 1 cycle.
  - WB (1 cycle):
    - Drive reg_waddr=rd, reg_wdata=result, reg_wen=1; reg_wen=0 if rd==0.
    - done=1 in this same cycle.
    - Go to IDLE.
- Latency: start sampled at edge E0 → RD in [E0,E1) → CAP → EXE → WB/done in [E3,E4).
  - Iterative shift adds shamt cycles.
- Arithmetic rules:
  - All results are XLEN bits; ADD/SUB wrap modulo 2^XLEN.
  - Shift amount = B[log2(XLEN)-1:0].
  - SLT is signed compare, SLTU unsigned; result is zero-extended 0/1.
- stall=1:
  - FSM, counters and operands hold; done and illegal are suppressed.
  - Bus goes to Z; the same state reasserts when stall drops.
  - start in IDLE during stall is ignored and not queued.
- start while busy: ignored.
- busy=1 in every state except IDLE.

Test Plan:
- Reset, then idle: all bus signals Z, busy=0. Assert hrstn low during EXE: returns to IDLE, no reg_wen ever seen.
- Regfile x1=7, x2=5. op=SUB, rs1=1, rs2=2, rd=3: ren pulses both ports in cycle 1; reg_wen=1, waddr=3, wdata=2, done=1 exactly 3 cycles after start; x3=0xFFFFFFFE with x1=5, x2=7.
- imm_sel=1, op=ADD, x1=0xFFFFFFFF, imm=1, rd=4: reg_ren_2 stays Z; wdata=0. Then op=SLT with x1=0x80000000, imm=0 → wdata=1; op=SLTU same operands → wdata=0.
- SHIFT_ITER=1, op=SRA, x1=0x80000000, x2=31: WB occurs 3+31 cycles after start, wdata=0xFFFFFFFF. Same with x2=32 → shamt 0, wdata=0x80000000, WB after 3 cycles.
- rd=0 with op=OR: done pulses, reg_wen never driven. op=12: illegal pulses 1 cycle after start, busy stays 0. op=SUB with imm_sel=1: illegal pulses.
- stall held 4 cycles during RD: ren released to Z, reasserted after stall; WB delayed by exactly 4 cycles; start pulsed mid-op is ignored.
